// File: rtl/stream_pkg.sv
// Shared types and constants for the stream checker and its LFSR.
package stream_pkg;

  // Checker control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // XOR of the tapped bits; becomes the new LSB on each shift.
  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/stream_if.sv
// Valid/ready stream bundle between a data source and the checker.
interface stream_if #(
  parameter int DW = 16
) ();
  logic          vld;
  logic [DW-1:0] dat;
  logic          rdy;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/stream_lfsr.sv
// 16-bit Fibonacci LFSR that shifts left while en is high.
module stream_lfsr
  import stream_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] w_q_next;

  assign w_q_next[0] = lfsr_feedback(r_q);

  genvar gi;
  generate
    for (gi = 1; gi < LFSR_W; gi++) begin : g_shift
      assign w_q_next[gi] = r_q[gi-1];
    end
  endgenerate

  // Load the seed on reset, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/stream_checker.sv
// Sink that applies pseudo-random backpressure, checks an incrementing
// data pattern, counts transfers and flags handshake violations.
module stream_checker
  import stream_pkg::*;
#(
  parameter int          DW   = 16,
  parameter int unsigned DN   = 16,
  parameter int unsigned RND  = 50,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  stream_if.slave       s,
  output logic [31:0]   cnt,
  output logic [15:0]   err_cnt,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_dat,
  output logic          prot_err,
  output logic          done
);

  localparam logic [31:0] DN_W  = DN;
  localparam logic [8:0]  RND_W = 9'(RND);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_rdy;
  logic [31:0]   r_cnt;
  logic [15:0]   r_err_cnt;
  logic [DW-1:0] r_exp;
  logic [DW-1:0] r_err_exp;
  logic [DW-1:0] r_err_dat;
  logic          r_stall;
  logic [DW-1:0] r_stall_dat;
  logic          r_prot_err;

  logic [LFSR_W-1:0] w_lfsr;
  logic [7:0]        w_lfsr_lo;
  logic              w_trn;
  logic              w_last;
  logic              w_prot_viol;

  // rdy is only ever high in RUN, so the handshake alone qualifies a transfer.
  assign w_trn     = s.vld & r_rdy;
  assign w_last    = w_trn && (r_cnt == DN_W - 32'd1);
  assign w_lfsr_lo = 8'(w_lfsr);

  stream_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (r_state == ST_RUN),
    .q   (w_lfsr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Re-enabling after a completed run goes straight to
  // DONE so no transfer beyond DN can ever be accepted.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_next = (r_cnt == DN_W) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!en) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Ready, counters, expected-data tracking and first-mismatch capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdy     <= 1'b0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
      r_exp     <= '0;
      r_err_exp <= '0;
      r_err_dat <= '0;
    end else begin
      r_rdy <= (w_state_next == ST_RUN) && ({1'b0, w_lfsr_lo} >= RND_W);
      if (w_trn) begin
        r_cnt <= r_cnt + 32'd1;
        r_exp <= r_exp + 1'b1;
        if (s.dat != r_exp) begin
          if (r_err_cnt == 16'd0) begin
            r_err_exp <= r_exp;
            r_err_dat <= s.dat;
          end
          if (r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
          end
        end
      end
    end
  end

  // A stall seen in RUN obliges the source to hold vld and dat next cycle.
  assign w_prot_viol = r_stall && (r_state == ST_RUN) &&
                       (!s.vld || (s.dat != r_stall_dat));

  // Stall history and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall     <= 1'b0;
      r_stall_dat <= '0;
      r_prot_err  <= 1'b0;
    end else begin
      r_stall     <= (r_state == ST_RUN) && s.vld && !r_rdy;
      r_stall_dat <= s.dat;
      if (w_prot_viol) begin
        r_prot_err <= 1'b1;
      end
    end
  end

  assign s.rdy    = r_rdy;
  assign cnt      = r_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_exp  = r_err_exp;
  assign err_dat  = r_err_dat;
  assign prot_err = r_prot_err;
  assign done     = (r_cnt == DN_W);

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: three instances (no backpressure, heavy
// backpressure, 4-bit data) share one source selected by sel.
module tb_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_s;
  logic        vld_s;
  logic [15:0] dat_s;
  logic [1:0]  sel;

  int checks = 0;
  int errors = 0;

  // Reference model state: transfers accepted, mismatches, first mismatch.
  int unsigned m_cnt;
  int          m_err;
  logic [15:0] m_eexp;
  logic [15:0] m_edat;
  logic [15:0] m_mask;
  int          src_idx;

  always #5 clk = ~clk;

  stream_if #(.DW(16)) ifa ();
  stream_if #(.DW(16)) ifb ();
  stream_if #(.DW(4))  ifc ();

  assign ifa.vld = vld_s & (sel == 2'd0);
  assign ifb.vld = vld_s & (sel == 2'd1);
  assign ifc.vld = vld_s & (sel == 2'd2);
  assign ifa.dat = dat_s;
  assign ifb.dat = dat_s;
  assign ifc.dat = dat_s[3:0];

  logic [31:0] cnt_a, cnt_b, cnt_c;
  logic [15:0] errc_a, errc_b, errc_c;
  logic [15:0] eexp_a, eexp_b, edat_a, edat_b;
  logic [3:0]  eexp_c, edat_c;
  logic        perr_a, perr_b, perr_c, done_a, done_b, done_c;

  stream_checker #(.DW(16), .DN(16), .RND(0)) dut_a (
    .clk(clk), .rst(rst_n), .en(en_s & (sel == 2'd0)), .s(ifa),
    .cnt(cnt_a), .err_cnt(errc_a), .err_exp(eexp_a), .err_dat(edat_a),
    .prot_err(perr_a), .done(done_a)
  );

  stream_checker #(.DW(16), .DN(16), .RND(128)) dut_b (
    .clk(clk), .rst(rst_n), .en(en_s & (sel == 2'd1)), .s(ifb),
    .cnt(cnt_b), .err_cnt(errc_b), .err_exp(eexp_b), .err_dat(edat_b),
    .prot_err(perr_b), .done(done_b)
  );

  stream_checker #(.DW(4), .DN(20), .RND(100)) dut_c (
    .clk(clk), .rst(rst_n), .en(en_s & (sel == 2'd2)), .s(ifc),
    .cnt(cnt_c), .err_cnt(errc_c), .err_exp(eexp_c), .err_dat(edat_c),
    .prot_err(perr_c), .done(done_c)
  );

  logic        rdy_s, perr_s, done_s;
  logic [31:0] cnt_s;
  logic [15:0] errc_s, eexp_s, edat_s;

  always_comb begin
    rdy_s  = ifa.rdy;
    cnt_s  = cnt_a;
    errc_s = errc_a;
    eexp_s = eexp_a;
    edat_s = edat_a;
    perr_s = perr_a;
    done_s = done_a;
    if (sel == 2'd1) begin
      rdy_s  = ifb.rdy;
      cnt_s  = cnt_b;
      errc_s = errc_b;
      eexp_s = eexp_b;
      edat_s = edat_b;
      perr_s = perr_b;
      done_s = done_b;
    end else if (sel == 2'd2) begin
      rdy_s  = ifc.rdy;
      cnt_s  = cnt_c;
      errc_s = errc_c;
      eexp_s = {12'h000, eexp_c};
      edat_s = {12'h000, edat_c};
      perr_s = perr_c;
      done_s = done_c;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_err   = 0;
    m_eexp  = 16'h0000;
    m_edat  = 16'h0000;
    src_idx = 0;
  endtask

  // Word k of a clean run is k modulo 2^DW; anything else is a mismatch.
  task automatic model_accept(input logic [15:0] d);
    logic [15:0] want;
    want = 16'(m_cnt) & m_mask;
    if ((d & m_mask) != want) begin
      if (m_err == 0) begin
        m_eexp = want;
        m_edat = d & m_mask;
      end
      if (m_err < 65535) m_err++;
    end
    m_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_s  = 1'b0;
    vld_s = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_status(input string tag, input logic exp_done,
                              input logic exp_perr, input logic rdy_low);
    @(negedge clk);
    chk({tag, ".cnt"},  cnt_s,  m_cnt);
    chk({tag, ".errc"}, 32'(errc_s), 32'(m_err));
    chk({tag, ".eexp"}, 32'(eexp_s), 32'(m_eexp));
    chk({tag, ".edat"}, 32'(edat_s), 32'(m_edat));
    chk({tag, ".done"}, 32'(done_s), 32'(exp_done));
    chk({tag, ".perr"}, 32'(perr_s), 32'(exp_perr));
    if (rdy_low) chk({tag, ".rdy"}, 32'(rdy_s), 32'd0);
  endtask

  // Legal source: holds a word until accepted, may idle between words.
  task automatic run_words(input string tag, input int n, input int gap_pct,
                           input int corrupt_pct, input int bad_idx,
                           input logic [15:0] bad_val, input logic rdy_chk,
                           output int cycles, output int stalls);
    int   sent;
    logic pending;
    sent    = 0;
    pending = 1'b0;
    cycles  = 0;
    stalls  = 0;
    while (sent < n && cycles < 2000) begin
      if (!pending) begin
        if ($urandom_range(99) < 32'(gap_pct)) begin
          vld_s = 1'b0;
        end else begin
          vld_s = 1'b1;
          dat_s = 16'(src_idx) & m_mask;
          if (src_idx == bad_idx) dat_s = bad_val;
          else if ($urandom_range(99) < 32'(corrupt_pct)) dat_s = 16'($urandom());
          pending = 1'b1;
        end
      end
      @(negedge clk);
      cycles++;
      if (rdy_chk) chk({tag, ".rdy_hi"}, 32'(rdy_s), 32'd1);
      if (vld_s && !rdy_s) stalls++;
      if (vld_s && rdy_s) begin
        model_accept(dat_s);
        src_idx++;
        sent++;
        pending = 1'b0;
      end
      tick();
    end
    vld_s = 1'b0;
    chk({tag, ".sent"}, 32'(sent), 32'(n));
  endtask

  // Present words until a stall is seen; returns with vld held in that cycle.
  task automatic find_stall(input string tag);
    int found;
    found = 0;
    vld_s = 1'b1;
    dat_s = 16'h0000;
    for (int i = 0; i < 500 && found == 0; i++) begin
      @(negedge clk);
      if (!rdy_s) begin
        found = 1;
      end else begin
        model_accept(dat_s);
        src_idx++;
      end
      tick();
      if (found == 0) dat_s = 16'(src_idx);
    end
    chk({tag, ".found"}, 32'(found), 32'd1);
  endtask

  initial begin
    int cyc, stl;
    sel    = 2'd0;
    dat_s  = 16'h0000;
    m_mask = 16'hFFFF;

    // Reset state, then vld while idle must be ignored.
    do_reset();
    check_status("rst", 1'b0, 1'b0, 1'b1);
    vld_s = 1'b1;
    dat_s = 16'h1234;
    repeat (3) tick();
    vld_s = 1'b0;
    check_status("idle_vld", 1'b0, 1'b0, 1'b1);

    // Nominal back-to-back run with rdy permanently high.
    en_s = 1'b1;
    tick();
    run_words("nom", 16, 0, 0, -1, 16'h0, 1'b1, cyc, stl);
    chk("nom.cycles", 32'(cyc), 32'd16);
    check_status("nom", 1'b1, 1'b0, 1'b1);

    // Word 5 corrupted; only the first mismatch is captured.
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("corr", 16, 0, 0, 5, 16'h0099, 1'b0, cyc, stl);
    check_status("corr", 1'b1, 1'b0, 1'b1);
    chk("corr.eexp_const", 32'(eexp_s), 32'h0005);
    chk("corr.edat_const", 32'(edat_s), 32'h0099);

    // Pausing via en keeps the counters; resuming completes the run.
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("pause1", 5, 20, 0, -1, 16'h0, 1'b0, cyc, stl);
    en_s = 1'b0;
    tick();
    tick();
    check_status("pause", 1'b0, 1'b0, 1'b1);
    en_s = 1'b1;
    tick();
    run_words("pause2", 11, 20, 0, -1, 16'h0, 1'b0, cyc, stl);
    check_status("resume", 1'b1, 1'b0, 1'b1);

    // Reset after 7 transfers, with a transfer attempted during reset.
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("mid1", 7, 0, 0, -1, 16'h0, 1'b0, cyc, stl);
    rst_n = 1'b0;
    vld_s = 1'b1;
    dat_s = 16'h0007;
    tick();
    rst_n = 1'b1;
    vld_s = 1'b0;
    en_s  = 1'b0;
    model_reset();
    check_status("midrst", 1'b0, 1'b0, 1'b1);
    en_s = 1'b1;
    tick();
    run_words("mid2", 16, 10, 0, -1, 16'h0, 1'b0, cyc, stl);
    check_status("rerun", 1'b1, 1'b0, 1'b1);

    // Heavy backpressure with a legal, occasionally idle source.
    sel = 2'd1;
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("bp", 16, 20, 0, -1, 16'h0, 1'b0, cyc, stl);
    chk("bp.stall_seen", 32'(stl > 0), 32'd1);
    check_status("bp", 1'b1, 1'b0, 1'b1);

    // Dropping vld during a stall is a protocol error, and it is sticky.
    do_reset();
    en_s = 1'b1;
    tick();
    find_stall("pdrop");
    vld_s = 1'b0;
    tick();
    @(negedge clk);
    chk("pdrop.perr", 32'(perr_s), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("pdrop.sticky", 32'(perr_s), 32'd1);

    // Changing dat during a stall is a protocol error.
    do_reset();
    @(negedge clk);
    chk("pchg.cleared", 32'(perr_s), 32'd0);
    tick();
    en_s = 1'b1;
    tick();
    find_stall("pchg");
    dat_s = dat_s ^ 16'h00A5;
    tick();
    vld_s = 1'b0;
    @(negedge clk);
    chk("pchg.perr", 32'(perr_s), 32'd1);

    // 4-bit data wraps 15 -> 0 without error over 20 transfers.
    sel    = 2'd2;
    m_mask = 16'h000F;
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("wrap", 20, 10, 0, -1, 16'h0, 1'b0, cyc, stl);
    check_status("wrap", 1'b1, 1'b0, 1'b1);

    // Randomly corrupted words against the reference model.
    do_reset();
    en_s = 1'b1;
    tick();
    run_words("rnd", 20, 30, 30, -1, 16'h0, 1'b0, cyc, stl);
    check_status("rnd", 1'b1, 1'b0, 1'b1);

    en_s = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter DW, default 16: stream data width in bits.
REQ-002 Parameter DN, default 16: number of transfers to accept before completion; range 1..2^32-1.
REQ-003 Parameter RND, default 50: backpressure threshold, 0..255; RND=0 means rdy is always high while running.
REQ-004 Parameter SEED, default 16'hACE1: nonzero LFSR seed.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-low; rst=0 at a clk rising edge resets the block.
REQ-007 Port en, input, 1 bit: start/run enable.
REQ-008 Port vld, input, 1 bit: upstream data valid.
REQ-009 Port dat, input, DW bits: upstream data.
REQ-010 Port rdy, output, 1 bit: ready to upstream, registered.
REQ-011 Port cnt, output, 32 bits: accepted transfer count.
REQ-012 Port err_cnt, output, 16 bits: data mismatch count, saturating at 16'hFFFF.
REQ-013 Port err_exp, output, DW bits: expected value at the first mismatch.
REQ-014 Port err_dat, output, DW bits: received value at the first mismatch.
REQ-015 Port prot_err, output, 1 bit: sticky handshake-violation flag.
REQ-016 Port done, output, 1 bit: high once cnt==DN.

Function
REQ-017 Transfer trn = vld & rdy; exactly one word is consumed per cycle with trn=1.
REQ-018 FSM states: IDLE, RUN and DONE.
REQ-019 IDLE -> RUN on en=1; RUN -> DONE on the cycle cnt reaches DN; DONE -> IDLE on en=0; RUN -> IDLE on en=0, with counters retained.
REQ-020 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle in RUN and holds in the other states.
REQ-021 Next-cycle rdy = (state_next==RUN) & (lfsr[7:0] >= RND); rdy is 0 in IDLE and DONE.
REQ-022 rdy does not depend combinationally on vld.
REQ-023 Expected-data register starts at 0 and increments by 1 modulo 2^DW on every trn, whether or not that word matched; there is no resynchronisation.
REQ-024 Mismatch on trn with dat != expected: err_cnt+1 (saturating); err_exp and err_dat are captured only when err_cnt was 0.
REQ-025 cnt increments on every trn; done asserts the cycle after the DN-th transfer and rdy is 0 from that same cycle.
REQ-026 Protocol check, stalled condition: if vld=1 & rdy=0 in cycle N, then cycle N+1 requires vld=1 and unchanged dat.
REQ-027 Protocol check, violation: any breach of REQ-026 sets prot_err, which stays set until reset.
REQ-028 vld while in IDLE or DONE is ignored: no count and no protocol error.
REQ-029 Wrap-around: expected-data wrap from 2^DW-1 to 0 is not an error; cnt does not wrap before DN.

Reset
REQ-030 On rst=0 the block enters IDLE, including mid-transfer, with these values: rdy=0, cnt=0, err_cnt=0, err_exp=0, err_dat=0, prot_err=0, done=0, expected=0, lfsr=SEED, stall history cleared.
REQ-031 A transfer coinciding with rst=0 is discarded.

Structure
REQ-032 Shared package stream_pkg holds the FSM state enum, the LFSR width, the tap constant and the default SEED.
REQ-033 The LFSR is a sub-module, stream_lfsr, with ports clk, rst, en and q[15:0]; the rest of the logic is in stream_checker.
REQ-034 The target implementation size is 120-400 lines of RTL.

Verification
REQ-035 Nominal: RND=0, DN=16, en=1, source sends 0..15 back-to-back -> rdy high continuously, 16 transfers in 16 cycles, done=1, cnt=16, err_cnt=0, prot_err=0.
REQ-036 Corruption: word 5 sent as 16'h0099 -> err_cnt=1, err_exp=16'h0005, err_dat=16'h0099; words 6..15 cause no further errors.
REQ-037 Backpressure: RND=128, DN=16 -> at least one rdy=0 cycle; all 16 words accepted in order; err_cnt=0; done=1.
REQ-038 Protocol: with rdy=0 and vld=1, source drops vld for one cycle -> prot_err=1; with dat changed while stalled instead -> prot_err=1.
REQ-039 Wrap: DW=4, DN=20, data 0..15 then 0..3 -> err_cnt=0, cnt=20.
REQ-040 Reset mid-run: rst=0 after 7 transfers -> all outputs return to reset values; re-run with data from 0 completes cleanly.
